// File: rtl/serial_cla_pkg.sv
// Shared definitions for the nibble-serial carry-look-ahead sequencer.
package serial_cla_pkg;

    // Width of one serial step; the adder instance is fixed at this width.
    localparam int NIB_W = 4;

    // Sequencer states
    //   IDLE | waiting for an operation, start_ready high
    //   RUN  | one nibble per cycle through the CLA, LSB nibble first
    //   DONE | results published, done pulse high for this single cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Two's-complement overflow: both operands share a sign and the result does not.
    function automatic logic add_overflow(input logic a_msb,
                                          input logic b_msb,
                                          input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage : serial_cla_pkg

// File: rtl/Carry_Look_Ahead_Adder_4bit.sv
// 4-bit carry-look-ahead adder: all carries formed directly from generate/propagate.
module Carry_Look_Ahead_Adder_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Flat look-ahead carry equations, no ripple between bit positions.
    always_comb begin
        c[0] = cin_i;
        c[1] = g[0] | (p[0] & cin_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin_i);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin_i);
    end

    assign sum_o  = p ^ c[3:0];
    assign cout_o = c[4];

endmodule : Carry_Look_Ahead_Adder_4bit

// File: rtl/serial_cla_sequencer.sv
// Nibble-serial add/subtract built around a single 4-bit CLA.
// One operation takes NNIB RUN cycles plus one DONE cycle; published
// results only change at the RUN->DONE transition.
module serial_cla_sequencer
    import serial_cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NNIB  = WIDTH / NIB_W;
    localparam int IDX_W = $clog2(NNIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic [NIB_W-1:0] cla_sum;
    logic             cla_cout;

    // Current-nibble operand selection feeding the shared adder.
    assign nib_a = a_q[idx_q*NIB_W +: NIB_W];
    assign nib_b = b_q[idx_q*NIB_W +: NIB_W];

    Carry_Look_Ahead_Adder_4bit u_cla (
        .a_i    (nib_a),
        .b_i    (nib_b),
        .cin_i  (carry_q),
        .sum_o  (cla_sum),
        .cout_o (cla_cout)
    );

    // Next-state, datapath loads and result publication.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    // Subtract is A + ~B + 1, so the carry register doubles as the +1.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[idx_q*NIB_W +: NIB_W] = cla_sum;
                carry_d = cla_cout;
                if (idx_q == LAST_IDX) begin
                    // The top nibble is taken straight from the adder so all
                    // three results appear together on entry to DONE.
                    sum_d   = res_d;
                    cout_d  = cla_cout;
                    ovf_d   = add_overflow(a_q[WIDTH-1], b_q[WIDTH-1],
                                           cla_sum[NIB_W-1]);
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == RUN) || (state_q == DONE);
    assign done        = done_q;
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign overflow    = ovf_q;

endmodule : serial_cla_sequencer

// File: tb/tb_serial_cla_sequencer.sv
module tb_serial_cla_sequencer;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;

    int checks;
    int failures;
    logic [15:0] prev_sum;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vcin;
        logic        vsub;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    vec_t vecs[12];

    serial_cla_sequencer #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .sub         (sub),
        .busy        (busy),
        .done        (done),
        .sum         (sum),
        .cout        (cout),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Caller sits at a negedge. Drives the op, then drives (na,nb,...) during
    // RUN to confirm latched operands are not disturbed.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                          input logic tcin, input logic tsub,
                          input logic [15:0] na, input logic [15:0] nb,
                          input logic ncin, input logic nsub, input logic keep_valid,
                          input logic [15:0] es, input logic ec, input logic eo,
                          input string nm);
        int n;
        bit got;
        n = 0;
        while (!start_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            chk({nm, " ready_timeout"}, 32'(start_ready), 32'd1);
            return;
        end
        start_valid = 1'b1;
        a = ta; b = tb; cin = tcin; sub = tsub;
        @(posedge clk);
        @(negedge clk);
        start_valid = keep_valid;
        a = na; b = nb; cin = ncin; sub = nsub;
        n = 1;
        got = 0;
        while (n <= 10) begin
            if (done) begin
                got = 1;
                break;
            end
            chk({nm, " hold_sum"}, 32'(sum), 32'(prev_sum));
            chk({nm, " busy_run"}, 32'(busy), 32'd1);
            @(negedge clk);
            n++;
        end
        chk({nm, " done_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({nm, " latency"}, 32'(n), 32'd5);
            chk({nm, " sum"}, 32'(sum), 32'(es));
            chk({nm, " cout"}, 32'(cout), 32'(ec));
            chk({nm, " overflow"}, 32'(overflow), 32'(eo));
            chk({nm, " busy_done"}, 32'(busy), 32'd1);
            chk({nm, " ready_done"}, 32'(start_ready), 32'd0);
            prev_sum = es;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        prev_sum = 16'h0000;
        rst = 1'b1;
        start_valid = 1'b0;
        a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0;

        //           a        b        cin   sub   sum      cout  ovf
        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4]  = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7]  = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[9]  = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'hCF13, 1'b0, 1'b0};
        vecs[10] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[11] = '{16'h7000, 16'h9000, 1'b0, 1'b1, 16'hE000, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst start_ready", 32'(start_ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst cout", 32'(cout), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
                   ~vecs[i].va, ~vecs[i].vb, ~vecs[i].vcin, ~vecs[i].vsub, 1'b0,
                   vecs[i].es, vecs[i].ec, vecs[i].eo, $sformatf("vec%0d", i));
        end

        // Back-to-back: valid held high, second operands presented during RUN.
        run_op(16'h1234, 16'h0FFF, 1'b1, 1'b0,
               16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1,
               16'h2234, 1'b0, 1'b0, "b2b_first");
        @(negedge clk);
        chk("b2b ready_after_done", 32'(start_ready), 32'd1);
        chk("b2b done_one_cycle", 32'(done), 32'd0);
        run_op(16'h0001, 16'h0002, 1'b0, 1'b0,
               16'hAAAA, 16'h5555, 1'b1, 1'b1, 1'b0,
               16'h0003, 1'b0, 1'b0, "b2b_second");

        // Reset during the second RUN cycle aborts and clears the last result.
        @(negedge clk);
        @(negedge clk);
        start_valid = 1'b1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort sum", 32'(sum), 32'd0);
        chk("abort ready", 32'(start_ready), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        prev_sum = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0,
               16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0,
               16'h3333, 1'b0, 1'b0, "after_reset");

        @(negedge clk);
        chk("final done_low", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_cla_sequencer

// File: doc/serial_cla_sequencer.md
SERIAL_CLA_SEQUENCER -- requirements
Module: serial_cla_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 and at least 8.
REQ-002 SHALL have derived localparam NNIB = WIDTH/4, the number of nibble steps per operation.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: start_valid  input  1  requester presents an operation.
REQ-007 Port: start_ready  output  1  sequencer can accept an operation.
REQ-008 Port: a  input  WIDTH  operand A.
REQ-009 Port: b  input  WIDTH  operand B.
REQ-010 Port: cin  input  1  carry-in, used for add only.
REQ-011 Port: sub  input  1  1 = A-B, 0 = A+B+cin.
REQ-012 Port: busy  output  1  operation in progress.
REQ-013 Port: done  output  1  one-cycle completion pulse.
REQ-014 Port: sum  output  WIDTH  result.
REQ-015 Port: cout  output  1  final carry; for subtract, 1 = no borrow.
REQ-016 Port: overflow  output  1  two's-complement overflow.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 start_ready SHALL equal 1 only in IDLE.
REQ-019 busy SHALL equal 1 in RUN and in DONE.
REQ-020 Accept SHALL occur when start_valid and start_ready are both 1 at a clock edge.
REQ-021 On accept, the block SHALL latch: a; b_eff = sub ? ~b : b; carry register = sub ? 1 : cin; nibble index = 0; state goes to RUN.
REQ-022 Each RUN cycle SHALL add nibble[idx] of A, B_eff and the carry register through one 4-bit CLA instance, store the 4-bit result into internal nibble[idx], load the carry register with the CLA carry-out, and increment idx.
REQ-023 When idx = NNIB-1, the RUN cycle SHALL move to DONE instead of incrementing idx.
REQ-024 On entry to DONE, the block SHALL load sum, cout and overflow together; done SHALL be 1 for exactly the DONE cycle; the next state SHALL be IDLE.
REQ-025 overflow SHALL equal (A[WIDTH-1] == B_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]).
REQ-026 Latency SHALL be fixed: done is high in cycle NNIB+1 after the accept edge, which is cycle 5 for WIDTH=16.
REQ-027 Throughput SHALL be one operation per NNIB+2 cycles; the next accept is possible in the cycle after done.
REQ-028 sum, cout and overflow SHALL hold their value from the last completion until the next completion; partial results SHALL never be visible on them.
REQ-029 start_valid and operand changes during RUN or DONE SHALL be ignored; latched operands SHALL be unaffected.
REQ-030 start_valid held high continuously SHALL produce back-to-back operations, each accepted in IDLE.
REQ-031 Arithmetic SHALL be modulo 2^WIDTH; the carry out of the last nibble SHALL be cout; no extension bits SHALL be kept.

Reset
REQ-032 While rst = 1, the state SHALL be IDLE, and idx, the carry register, internal nibbles, sum, cout, overflow and done SHALL be 0.
REQ-033 Output values under reset SHALL be start_ready = 1 and busy = 0.
REQ-034 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse, and the last result SHALL be cleared to 0.
REQ-035 After reset deasserts, the first accept SHALL be possible on the first clock edge.

Structure
REQ-036 The FSM state encoding and the nibble width constant (4) SHALL live in a shared package, serial_cla_pkg.
REQ-037 Exactly one sub-module instance SHALL exist, the existing 4-bit carry-look-ahead adder Carry_Look_Ahead_Adder_4bit, fed from the current-nibble muxes; no other adder logic SHALL be allowed.
REQ-038 The idx counter width SHALL be $clog2(NNIB).

Verification (WIDTH=16)
REQ-039 a=FFFF, b=0001, sub=0, cin=0 -> sum=0000, cout=1, overflow=0, done in cycle 5 after accept.
REQ-040 a=7FFF, b=0001, sub=0 -> sum=8000, cout=0, overflow=1.
REQ-041 a=0005, b=0007, sub=1 -> sum=FFFE, cout=0, overflow=0; then a=8000, b=0001, sub=1 -> sum=7FFF, cout=1, overflow=1.
REQ-042 a=1234, b=0FFF, cin=1, sub=0 -> sum=2234, cout=0; start_valid held high with new operands during RUN -> first result unchanged, second op accepted in the cycle after done.
REQ-043 Reset pulsed in cycle 2 of RUN -> no done pulse, sum=0, start_ready=1 immediately; a new op after reset -> correct result at the same latency.
